// File: rtl/vector_response_checker.sv
// rtl/vector_response_checker.sv - expected-vector table compared against a DUT response once per clock
// Optional macro VECTOR_MASK_EN adds a per-entry don't-care mask table and exp_mask input.
module vector_response_checker #(
  parameter int W     = 1,
  parameter int DEPTH = 5001,
  parameter int AW    = 13
) (
  input  logic          t_clock,
  input  logic          t_reset,
  input  logic          exp_we,
  input  logic [AW-1:0] exp_addr,
  input  logic [W-1:0]  exp_data,
`ifdef VECTOR_MASK_EN
  input  logic [W-1:0]  exp_mask,
`endif
  input  logic          start,
  input  logic [AW-1:0] num_vectors,
  input  logic [W-1:0]  obs,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW-1:0] vectornum,
  output logic [15:0]   err_count,
  output logic [AW-1:0] first_err_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  state_t        state_q, state_d;
  logic [AW-1:0] n_q, n_d;
  logic [AW-1:0] vnum_q, vnum_d;
  logic [AW-1:0] first_q, first_d;
  logic [15:0]   err_q, err_d;
  logic          pass_q, pass_d;
  logic [AW-1:0] n_start;
  logic          mismatch;

  logic [W-1:0]  exp_mem [DEPTH];

`ifdef VECTOR_MASK_EN
  logic [W-1:0]  mask_mem [DEPTH];
  assign mismatch = |((obs ^ exp_mem[vnum_q]) & mask_mem[vnum_q]);
`else
  assign mismatch = (obs != exp_mem[vnum_q]);
`endif

  // Table is frozen while a check is running; out-of-range writes are dropped.
  always_ff @(posedge t_clock) begin
    if (exp_we && (state_q != RUN) && (exp_addr < DEPTH_A)) begin
      exp_mem[exp_addr] <= exp_data;
`ifdef VECTOR_MASK_EN
      mask_mem[exp_addr] <= exp_mask;
`endif
    end
  end

  assign n_start = (num_vectors > DEPTH_A) ? DEPTH_A : num_vectors;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    vnum_d  = vnum_q;
    first_d = first_q;
    err_d   = err_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          n_d     = n_start;
          vnum_d  = '0;
          err_d   = '0;
          first_d = '1;
          if (n_start == '0) begin
            state_d = DONE;
            pass_d  = 1'b1;
          end else begin
            state_d = RUN;
            pass_d  = 1'b0;
          end
        end
      end
      RUN: begin
        if (mismatch) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          if (err_q == '0) first_d = vnum_q;
        end
        // vectornum parks on n-1 so it never wraps past the run length.
        if (vnum_q == n_q - AW'(1)) begin
          state_d = DONE;
          pass_d  = (err_d == '0);
        end else begin
          vnum_d = vnum_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge t_clock or posedge t_reset) begin
    if (t_reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      vnum_q  <= '0;
      first_q <= '1;
      err_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      vnum_q  <= vnum_d;
      first_q <= first_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

  assign busy          = (state_q == RUN);
  assign done          = (state_q == DONE);
  assign pass          = pass_q;
  assign vectornum     = vnum_q;
  assign err_count     = err_q;
  assign first_err_idx = first_q;

endmodule

// File: tb/tb_vector_response_checker.sv
// tb/tb_vector_response_checker.sv - scoreboard bench for vector_response_checker
// Honours VECTOR_MASK_EN (W becomes 2 and the mask cases run).
`timescale 1ns/1ps
module tb_vector_response_checker;
`ifdef VECTOR_MASK_EN
  localparam int W = 2;
`else
  localparam int W = 1;
`endif
  localparam int DEPTH = 5001;
  localparam int AW    = 13;
  localparam int NONE  = (1 << AW) - 1;

  logic          t_clock = 1'b0;
  logic          t_reset;
  logic          exp_we;
  logic [AW-1:0] exp_addr;
  logic [W-1:0]  exp_data;
  logic [W-1:0]  mask_in;
  logic          start;
  logic [AW-1:0] num_vectors;
  logic [W-1:0]  obs;
  logic          busy, done, pass;
  logic [AW-1:0] vectornum, first_err_idx;
  logic [15:0]   err_count;

  vector_response_checker #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
    .t_clock(t_clock), .t_reset(t_reset), .exp_we(exp_we), .exp_addr(exp_addr),
    .exp_data(exp_data),
`ifdef VECTOR_MASK_EN
    .exp_mask(mask_in),
`endif
    .start(start), .num_vectors(num_vectors), .obs(obs), .busy(busy), .done(done),
    .pass(pass), .vectornum(vectornum), .err_count(err_count), .first_err_idx(first_err_idx)
  );

  always #5 t_clock = ~t_clock;

  typedef struct {
    longint errs;
    longint first;
    longint pass;
    longint nbusy;
    longint lastvn;
  } exp_t;

  exp_t         sbq[$];
  logic [W-1:0] exp_model  [DEPTH];
  logic [W-1:0] mask_model [DEPTH];
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic tbl_write(input int addr, input logic [W-1:0] d, input logic [W-1:0] m);
    @(negedge t_clock);
    exp_we   = 1'b1;
    exp_addr = AW'(addr);
    exp_data = d;
    mask_in  = m;
    @(negedge t_clock);
    exp_we = 1'b0;
    if (addr < DEPTH) begin
      exp_model[addr]  = d;
      mask_model[addr] = m;
    end
  endtask

  // Expected outcome of a run, derived from the table model and the obs list.
  task automatic run(input int nreq, input logic [W-1:0] o[$], input bit poke);
    int   n     = (nreq > DEPTH) ? DEPTH : nreq;
    int   errs  = 0;
    int   first = NONE;
    exp_t e;
    for (int k = 0; k < n; k++) begin
      if (((o[k] ^ exp_model[k]) & mask_model[k]) != '0) begin
        if (errs == 0) first = k;
        errs++;
      end
    end
    e.errs   = (errs > 65535) ? 65535 : errs;
    e.first  = first;
    e.pass   = (errs == 0) ? 1 : 0;
    e.nbusy  = n;
    e.lastvn = (n == 0) ? 0 : n - 1;
    sbq.push_back(e);
    @(negedge t_clock);
    start       = 1'b1;
    num_vectors = AW'(nreq);
    @(negedge t_clock);
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      obs = o[k];
      if (poke && k == 1) begin
        exp_we   = 1'b1;
        exp_addr = AW'(2);
        exp_data = ~exp_model[2];
        mask_in  = '1;
      end else begin
        exp_we = 1'b0;
      end
      @(negedge t_clock);
    end
    exp_we = 1'b0;
    repeat (2) @(negedge t_clock);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_vectornum"}, vectornum, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_first_err_idx"}, first_err_idx, NONE);
  endtask

  // Monitor: a completed run is a done level following a busy cycle or an accepted start.
  initial begin
    int   bcnt = 0;
    logic s_start, s_busy, s_rst;
    exp_t e;
    forever begin
      @(posedge t_clock);
      s_start = start;
      s_busy  = busy;
      s_rst   = t_reset;
      #1;
      if (t_reset || s_rst) begin
        bcnt = 0;
      end else begin
        if (busy) bcnt++;
        if (done && (s_busy || s_start)) begin
          if (sbq.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sbq.pop_front();
            check("err_count", err_count, e.errs);
            check("first_err_idx", first_err_idx, e.first);
            check("pass", pass, e.pass);
            check("busy_cycles", bcnt, e.nbusy);
            check("last_vectornum", vectornum, e.lastvn);
          end
          bcnt = 0;
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] o1[$];
    logic [W-1:0] o2[$];
    logic [W-1:0] ro[$];
    int           n;
    t_reset = 1'b1; start = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_data = '0;
    mask_in = '1; num_vectors = '0; obs = '0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_model[i]  = '0;
      mask_model[i] = '1;
    end
    repeat (2) @(negedge t_clock);
    check_reset_values("reset");
    t_reset = 1'b0;

    tbl_write(0, W'(1), '1);
    tbl_write(1, W'(0), '1);
    tbl_write(2, W'(0), '1);
    tbl_write(3, W'(0), '1);
    tbl_write(8000, W'(1), '1);
    o1 = '{W'(1), W'(0), W'(0), W'(0)};
    o2 = '{W'(1), W'(1), W'(0), W'(1)};
    run(4, o1, 1'b0);
    run(4, o2, 1'b0);
    run(0, o1, 1'b0);

    // Abort after the second compare, then rerun from the kept table.
    @(negedge t_clock);
    start = 1'b1; num_vectors = AW'(4);
    @(negedge t_clock);
    start = 1'b0; obs = o2[0];
    @(negedge t_clock);
    obs = o2[1];
    @(negedge t_clock);
    t_reset = 1'b1;
    #1;
    check_reset_values("abort");
    @(negedge t_clock);
    t_reset = 1'b0;
    run(4, o1, 1'b0);

    run(4, o1, 1'b1);
    run(4, o2, 1'b0);
    run(4, o1, 1'b0);

    for (int i = 0; i < 64; i++) tbl_write(i, W'($urandom), '1);
    for (int r = 0; r < 20; r++) begin
      n = ($urandom_range(4) == 0) ? 0 : int'($urandom_range(64, 1));
      ro = {};
      for (int k = 0; k < n; k++)
        ro.push_back(($urandom_range(3) == 0) ? W'($urandom) : exp_model[k]);
      run(n, ro, 1'b0);
    end

`ifdef VECTOR_MASK_EN
    tbl_write(0, 2'b10, 2'b10);
    ro = '{2'b11};
    run(1, ro, 1'b0);
    tbl_write(0, 2'b10, 2'b11);
    run(1, ro, 1'b0);
`endif

    for (int i = 64; i < DEPTH; i++) tbl_write(i, W'($urandom), '1);
    ro = {};
    for (int k = 0; k < DEPTH; k++)
      ro.push_back(($urandom_range(7) == 0) ? W'($urandom) : exp_model[k]);
    run(NONE, ro, 1'b0);

    repeat (3) @(negedge t_clock);
    check("scoreboard_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
